// File: rtl/ex_stage.sv
// Execute stage: 32-bit ALU with signed-overflow detection feeding the EX/MEM
// pipeline register, with stall/flush control and interrupt/overflow trapping.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] id_pc,
  input  logic        id_en,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_alu_in_0,
  input  logic [31:0] id_alu_in_1,
  input  logic        id_br_flag,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] id_mem_wr_data,
  input  logic [1:0]  id_ctrl_op,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic [2:0]  id_exp_code,
  input  logic        int_detect,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] ex_fwd_data,
  output logic [29:0] ex_pc,
  output logic        ex_en,
  output logic        ex_br_flag,
  output logic [1:0]  ex_mem_op,
  output logic [31:0] ex_mem_wr_data,
  output logic [1:0]  ex_ctrl_op,
  output logic [4:0]  ex_dst_addr,
  output logic        ex_gpr_we_,
  output logic [2:0]  ex_exp_code,
  output logic [31:0] ex_out
);

  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADDS = 4'd4;
  localparam logic [3:0] OP_ADDU = 4'd5;
  localparam logic [3:0] OP_SUBS = 4'd6;
  localparam logic [3:0] OP_SUBU = 4'd7;
  localparam logic [3:0] OP_SHRL = 4'd8;
  localparam logic [3:0] OP_SHLL = 4'd9;

  localparam logic [2:0] EXP_EXT_INT  = 3'd1;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  logic [31:0] w_alu_res;
  logic        w_alu_of;
  logic [31:0] w_sum;
  logic [31:0] w_diff;

  logic [29:0] r_pc;
  logic        r_en;
  logic        r_br_flag;
  logic [1:0]  r_mem_op;
  logic [31:0] r_mem_wr_data;
  logic [1:0]  r_ctrl_op;
  logic [4:0]  r_dst_addr;
  logic        r_gpr_we_;
  logic [2:0]  r_exp_code;
  logic [31:0] r_out;

  assign w_sum  = id_alu_in_0 + id_alu_in_1;
  assign w_diff = id_alu_in_0 - id_alu_in_1;

  always_comb begin
    w_alu_res = id_alu_in_0;
    w_alu_of  = 1'b0;
    case (id_alu_op)
      OP_AND:  w_alu_res = id_alu_in_0 & id_alu_in_1;
      OP_OR:   w_alu_res = id_alu_in_0 | id_alu_in_1;
      OP_XOR:  w_alu_res = id_alu_in_0 ^ id_alu_in_1;
      OP_ADDS: begin
        w_alu_res = w_sum;
        w_alu_of  = (id_alu_in_0[31] == id_alu_in_1[31]) &&
                    (w_sum[31] != id_alu_in_0[31]);
      end
      OP_ADDU: w_alu_res = w_sum;
      OP_SUBS: begin
        w_alu_res = w_diff;
        w_alu_of  = (id_alu_in_0[31] != id_alu_in_1[31]) &&
                    (w_diff[31] != id_alu_in_0[31]);
      end
      OP_SUBU: w_alu_res = w_diff;
      OP_SHRL: w_alu_res = id_alu_in_0 >> id_alu_in_1[4:0];
      OP_SHLL: w_alu_res = id_alu_in_0 << id_alu_in_1[4:0];
      default: w_alu_res = id_alu_in_0;
    endcase
  end

  assign ex_fwd_data = w_alu_res;

  // Stall holds by leaving the registers unassigned; trap cases only squash
  // the memory op and GPR write and tag the exception, everything else loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= '0;
      r_en          <= 1'b0;
      r_br_flag     <= 1'b0;
      r_mem_op      <= '0;
      r_mem_wr_data <= '0;
      r_ctrl_op     <= '0;
      r_dst_addr    <= '0;
      r_gpr_we_     <= 1'b1;
      r_exp_code    <= '0;
      r_out         <= '0;
    end else if (stall) begin
    end else if (flush) begin
      r_pc          <= '0;
      r_en          <= 1'b0;
      r_br_flag     <= 1'b0;
      r_mem_op      <= '0;
      r_mem_wr_data <= '0;
      r_ctrl_op     <= '0;
      r_dst_addr    <= '0;
      r_gpr_we_     <= 1'b1;
      r_exp_code    <= '0;
      r_out         <= '0;
    end else begin
      r_pc          <= id_pc;
      r_en          <= id_en;
      r_br_flag     <= id_br_flag;
      r_mem_wr_data <= id_mem_wr_data;
      r_ctrl_op     <= id_ctrl_op;
      r_dst_addr    <= id_dst_addr;
      r_out         <= w_alu_res;
      if (id_en && int_detect) begin
        r_mem_op   <= '0;
        r_gpr_we_  <= 1'b1;
        r_exp_code <= EXP_EXT_INT;
      end else if (id_en && w_alu_of) begin
        r_mem_op   <= '0;
        r_gpr_we_  <= 1'b1;
        r_exp_code <= EXP_OVERFLOW;
      end else begin
        r_mem_op   <= id_mem_op;
        r_gpr_we_  <= id_gpr_we_;
        r_exp_code <= id_exp_code;
      end
    end
  end

  assign ex_pc          = r_pc;
  assign ex_en          = r_en;
  assign ex_br_flag     = r_br_flag;
  assign ex_mem_op      = r_mem_op;
  assign ex_mem_wr_data = r_mem_wr_data;
  assign ex_ctrl_op     = r_ctrl_op;
  assign ex_dst_addr    = r_dst_addr;
  assign ex_gpr_we_     = r_gpr_we_;
  assign ex_exp_code    = r_exp_code;
  assign ex_out         = r_out;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_pc  in  30  ID/EX PC.
- id_en  in  1  ID/EX valid.
- id_alu_op  in  4  ALU op.
- id_alu_in_0, id_alu_in_1  in  32  ALU operands.
- id_br_flag  in  1  branch flag.
- id_mem_op  in  2  memory op.
- id_mem_wr_data  in  32  store data.
- id_ctrl_op  in  2  ctrl op.
- id_dst_addr  in  5  GPR destination.
- id_gpr_we_  in  1  GPR write, active-low.
- id_exp_code  in  3  exception code.
- int_detect  in  1  external interrupt taken at this stage.
- stall, flush  in  1  pipeline control.
- ex_fwd_data  out  32  combinational ALU result, forwarded back to ID.
- ex_pc  out  30  registered PC.
- ex_en  out  1  registered valid.
- ex_br_flag  out  1  registered branch flag.
- ex_mem_op  out  2  registered memory op.
- ex_mem_wr_data  out  32  registered store data.
- ex_ctrl_op  out  2  registered ctrl op.
- ex_dst_addr  out  5  registered GPR destination.
- ex_gpr_we_  out  1  registered GPR write, active-low.
- ex_exp_code  out  3  registered exception code.
- ex_out  out  32  registered ALU result.

Function
REQ-002 ALU op encodings and results: NOP=0 passes in_0; AND=1; OR=2; XOR=3; ADDS=4; ADDU=5; SUBS=6; SUBU=7; SHRL=8 is a logical right shift of in_0 by in_1[4:0]; SHLL=9 is a left shift of in_0 by in_1[4:0]; codes 10-15 pass in_0.
REQ-003 All ALU arithmetic SHALL be 32-bit modulo 2^32, with carry-out discarded.
REQ-004 Overflow flag alu_of SHALL be asserted only in these cases:
- ADDS, when in_0[31]==in_1[31] and result[31]!=in_0[31].
- SUBS, when in_0[31]!=in_1[31] and result[31]!=in_0[31].
REQ-005 alu_of SHALL be 0 for every other op, including ADDU and SUBU.
REQ-006 ex_fwd_data SHALL equal the ALU result combinationally, with zero latency.
REQ-007 The EX/MEM register SHALL have latency 1: inputs sampled at edge N appear on the ex_* outputs after edge N.
REQ-008 Update priority on each clk edge, highest first:
- stall=1: all ex_* registers hold.
- flush=1: load the bubble (REQ-009).
- id_en=1 and int_detect=1: load per REQ-010 with ex_mem_op=NOP(0), ex_gpr_we_=1, ex_exp_code=EXT_INT(1).
- id_en=1 and alu_of=1: load per REQ-010 with ex_mem_op=NOP(0), ex_gpr_we_=1, ex_exp_code=OVERFLOW(3).
- otherwise: load all id_* inputs and the ALU result.
REQ-009 Bubble values: ex_pc=0, ex_en=0, ex_br_flag=0, ex_mem_op=0, ex_mem_wr_data=0, ex_ctrl_op=0, ex_dst_addr=0, ex_gpr_we_=1, ex_exp_code=0, ex_out=0.
REQ-010 In the interrupt and overflow cases, ex_pc, ex_en, ex_br_flag, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr and ex_out SHALL still load normally.
REQ-011 int_detect and alu_of SHALL be ignored when id_en=0; the register then loads the id_* inputs unchanged.
REQ-012 When stall and flush are both 1, stall SHALL win and the registers hold.
REQ-013 When int_detect and alu_of are both 1, EXT_INT SHALL win.

Reset
REQ-014 reset low SHALL force every registered output to its REQ-009 bubble value immediately, independent of clk.
REQ-015 Registered outputs SHALL stay at bubble values while reset is low.
REQ-016 A reset assertion mid-stall or mid-flush SHALL override both.
REQ-017 After reset deasserts, the first rising clk edge SHALL follow REQ-008.
REQ-018 ex_fwd_data SHALL remain combinational and unaffected by reset.

Verification
REQ-019 Reset: assert reset mid-cycle with valid inputs -> all registered outputs take bubble values with no clk edge; ex_gpr_we_=1.
REQ-020 Signed add overflow: ADDS, in_0=0x7FFFFFFF, in_1=1, id_en=1, id_gpr_we_=0, id_mem_op=1 -> ex_fwd_data=0x80000000 immediately; after the edge ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=0, ex_out=0x80000000.
REQ-021 Unsigned wrap: ADDU, same operands -> ex_exp_code=id_exp_code, ex_gpr_we_=0.
REQ-022 Unsigned borrow: SUBU, 0-1 -> ex_out=0xFFFFFFFF, no exception.
REQ-023 Shifts: SHLL, in_0=1, in_1=0x21 -> result 2 (only in_1[4:0] used); SHRL, in_0=0x80000000, in_1=31 -> result 1.
REQ-024 Stall/flush: stall=1 and flush=1 for 2 cycles with changing inputs -> outputs hold; then flush=1, stall=0 -> bubble after 1 edge.
REQ-025 Interrupt priority: int_detect=1 together with ADDS overflow, id_en=1 -> ex_exp_code=1.
REQ-026 Invalid slot: the same stimulus as REQ-025 with id_en=0 -> ex_exp_code=id_exp_code and ex_en=0.
